prog_counter_rs: RTL and testbench

- Parametrised successor to the RAT program counter: an N-bit PC with load/increment plus a 4-way next-address source mux.
- Adds an integrated hardware return-address stack (RAS), so CALL/RET no longer need scratch-RAM round trips.
- Sits between the control unit (LD/INC/SEL/PUSH/POP strobes) and the program ROM address input.

---
 rtl/prog_counter_rs_if.sv | 31 +++
 rtl/prog_counter_rs.sv | 105 ++++++++++
 tb/tb_prog_counter_rs.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_counter_rs_if.sv
// Control-unit side bundle for the program counter with return-address stack.
// The master drives the strobes and target; the slave reports PC and stack status.
interface prog_counter_rs_if #(
    parameter int N     = 10,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [N-1:0]  DIN;
    logic          PC_LD;
    logic          PC_INC;
    logic [1:0]    PC_MUX_SEL;
    logic          PC_PUSH;
    logic          PC_POP;
    logic [N-1:0]  PC_COUNT;
    logic [N-1:0]  STK_TOP;
    logic [DW-1:0] STK_DEPTH;
    logic          STK_FULL;
    logic          STK_EMPTY;
    logic          STK_ERR;

    modport master (
        output DIN, PC_LD, PC_INC, PC_MUX_SEL, PC_PUSH, PC_POP,
        input  PC_COUNT, STK_TOP, STK_DEPTH, STK_FULL, STK_EMPTY, STK_ERR
    );

    modport slave (
        input  DIN, PC_LD, PC_INC, PC_MUX_SEL, PC_PUSH, PC_POP,
        output PC_COUNT, STK_TOP, STK_DEPTH, STK_FULL, STK_EMPTY, STK_ERR
    );
endinterface

// File: rtl/prog_counter_rs.sv
// N-bit program counter with load/increment, 4-way next-address mux and an
// integrated return-address stack that saturates (no wrap) with a sticky error.
module prog_counter_rs #(
    parameter int          N        = 10,
    parameter int          DEPTH    = 8,
    parameter logic [N-1:0] INTR_VEC = N'(10'h3FF)
) (
    input logic              CLK,
    input logic              RST,
    prog_counter_rs_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  pc;
    logic [N-1:0]  pc_nxt;
    logic [N-1:0]  pc_inc1;
    logic [N-1:0]  stk_top;
    logic [N-1:0]  stk_mem [DEPTH];
    logic [DW-1:0] stk_depth;
    logic [DW-1:0] depth_nxt;
    logic          stk_err;
    logic          err_nxt;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    assign pc_inc1 = pc + N'(1);
    assign full    = (stk_depth == DW'(DEPTH));
    assign empty   = (stk_depth == '0);
    assign top_idx = AW'(stk_depth - DW'(1));
    assign stk_top = empty ? '0 : stk_mem[top_idx];

    // SEL 3 is reserved and holds the PC, suppressing any increment.
    always_comb begin
        pc_nxt = pc;
        if (bus.PC_LD) begin
            case (bus.PC_MUX_SEL)
                2'd0:    pc_nxt = bus.DIN;
                2'd1:    pc_nxt = stk_top;
                2'd2:    pc_nxt = INTR_VEC;
                default: pc_nxt = pc;
            endcase
        end else if (bus.PC_INC) begin
            pc_nxt = pc_inc1;
        end
    end

    always_comb begin
        depth_nxt = stk_depth;
        err_nxt   = stk_err;
        wr_en     = 1'b0;
        wr_idx    = AW'(stk_depth);
        case ({bus.PC_PUSH, bus.PC_POP})
            2'b10: begin
                if (full) begin
                    err_nxt = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    depth_nxt = stk_depth + DW'(1);
                end
            end
            2'b01: begin
                if (empty) err_nxt = 1'b1;
                else       depth_nxt = stk_depth - DW'(1);
            end
            2'b11: begin
                // Simultaneous push+pop swaps the top in place; on an empty stack it degrades to a push.
                wr_en = 1'b1;
                if (empty) begin
                    depth_nxt = DW'(1);
                    err_nxt   = 1'b1;
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc        <= '0;
            stk_depth <= '0;
            stk_err   <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            stk_depth <= depth_nxt;
            stk_err   <= err_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) stk_mem[wr_idx] <= pc_inc1;
    end

    assign bus.PC_COUNT  = pc;
    assign bus.STK_TOP   = stk_top;
    assign bus.STK_DEPTH = stk_depth;
    assign bus.STK_FULL  = full;
    assign bus.STK_EMPTY = empty;
    assign bus.STK_ERR   = stk_err;
endmodule

// File: tb/tb_prog_counter_rs.sv
// Self-checking bench for prog_counter_rs: directed vector table, multi-cycle
// reset/overflow sequences, and randomized traffic against a queue-based model.
module tb_prog_counter_rs;
    localparam int N     = 10;
    localparam int DEPTH = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    prog_counter_rs_if #(.N(N), .DEPTH(DEPTH)) bif ();

    prog_counter_rs #(.N(N), .DEPTH(DEPTH), .INTR_VEC(10'h3FF)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bif)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         rst;
        logic [9:0] din;
        bit         ld;
        bit         inc;
        logic [1:0] sel;
        bit         push;
        bit         pop;
        logic [9:0] e_pc;
        logic [9:0] e_top;
        int         e_depth;
        bit         e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [9:0] d, bit l, bit i, logic [1:0] s,
                                bit pu, bit po, logic [9:0] epc, logic [9:0] etop,
                                int edep, bit eerr);
        vec_t v;
        v.rst = r; v.din = d; v.ld = l; v.inc = i; v.sel = s; v.push = pu; v.pop = po;
        v.e_pc = epc; v.e_top = etop; v.e_depth = edep; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [9:0] d, input bit l, input bit i, input logic [1:0] s,
                         input bit pu, input bit po);
        bif.DIN = d; bif.PC_LD = l; bif.PC_INC = i; bif.PC_MUX_SEL = s;
        bif.PC_PUSH = pu; bif.PC_POP = po;
    endtask

    task automatic step(input logic [9:0] d, input bit l, input bit i, input logic [1:0] s,
                        input bit pu, input bit po);
        drive(d, l, i, s, pu, po);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive('0, 0, 0, 2'd0, 0, 0);
        #2 RST = 1'b1;
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [9:0] epc, input logic [9:0] etop,
                             input int edep, input bit eerr);
        chk({tag, ".pc"},    32'(bif.PC_COUNT),  32'(epc));
        chk({tag, ".top"},   32'(bif.STK_TOP),   32'(etop));
        chk({tag, ".depth"}, 32'(bif.STK_DEPTH), 32'(edep));
        chk({tag, ".full"},  32'(bif.STK_FULL),  32'(edep == DEPTH));
        chk({tag, ".empty"}, 32'(bif.STK_EMPTY), 32'(edep == 0));
        chk({tag, ".err"},   32'(bif.STK_ERR),   32'(eerr));
    endtask

    // Reference model: PC as plain integer arithmetic, stack as a bounded queue.
    int         m_pc;
    logic [9:0] m_stk[$];
    bit         m_err;

    task automatic model_step(input logic [9:0] d, input bit l, input bit i, input logic [1:0] s,
                              input bit pu, input bit po);
        int top  = (m_stk.size() == 0) ? 0 : int'(m_stk[m_stk.size() - 1]);
        int pv   = (m_pc + 1) % 1024;
        int npc  = m_pc;
        if (l) begin
            if (s == 2'd0)      npc = int'(d);
            else if (s == 2'd1) npc = top;
            else if (s == 2'd2) npc = 1023;
        end else if (i) begin
            npc = (m_pc + 1) % 1024;
        end
        if (pu && po) begin
            if (m_stk.size() == 0) begin
                m_stk.push_back(10'(pv));
                m_err = 1;
            end else begin
                m_stk[m_stk.size() - 1] = 10'(pv);
            end
        end else if (pu) begin
            if (m_stk.size() == DEPTH) m_err = 1;
            else m_stk.push_back(10'(pv));
        end else if (po) begin
            if (m_stk.size() == 0) m_err = 1;
            else void'(m_stk.pop_back());
        end
        m_pc = npc;
    endtask

    initial begin
        drive('0, 0, 0, 2'd0, 0, 0);
        #1;
        chk_state("por", 10'h000, 10'h000, 0, 0);
        #5 RST = 1'b0;
        @(posedge CLK);
        #1;

        // Mid-cycle reset must clear PC and the sticky error without a clock edge.
        step(10'h005, 1, 0, 2'd0, 0, 0);
        chk("pre_rst.pc", 32'(bif.PC_COUNT), 32'h5);
        step(10'h000, 0, 0, 2'd0, 0, 1);
        chk("pre_rst.err", 32'(bif.STK_ERR), 32'h1);
        drive('0, 0, 0, 2'd0, 0, 0);
        #3 RST = 1'b1;
        #1;
        chk_state("async_rst", 10'h000, 10'h000, 0, 0);
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;

        vecs.push_back(mk(0, 10'h000, 0, 1, 2'd0, 0, 0, 10'h001, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 1, 2'd0, 0, 0, 10'h002, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 1, 2'd0, 0, 0, 10'h003, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h3FF, 1, 0, 2'd0, 0, 0, 10'h3FF, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 1, 2'd0, 0, 0, 10'h000, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h007, 1, 0, 2'd0, 0, 0, 10'h007, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h120, 1, 1, 2'd0, 0, 0, 10'h120, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h007, 1, 0, 2'd0, 0, 0, 10'h007, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h120, 1, 1, 2'd3, 0, 0, 10'h007, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h120, 1, 1, 2'd2, 0, 0, 10'h3FF, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h010, 1, 0, 2'd0, 0, 0, 10'h010, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h200, 1, 0, 2'd0, 1, 0, 10'h200, 10'h011, 1, 0));
        vecs.push_back(mk(0, 10'h300, 1, 0, 2'd0, 1, 0, 10'h300, 10'h201, 2, 0));
        vecs.push_back(mk(0, 10'h000, 1, 0, 2'd1, 0, 1, 10'h201, 10'h011, 1, 0));
        vecs.push_back(mk(0, 10'h000, 1, 0, 2'd1, 0, 1, 10'h011, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 0, 2'd0, 0, 1, 10'h011, 10'h000, 0, 1));
        vecs.push_back(mk(1, 10'h040, 1, 0, 2'd0, 0, 0, 10'h040, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 0, 2'd0, 1, 0, 10'h040, 10'h041, 1, 0));
        vecs.push_back(mk(0, 10'h050, 1, 0, 2'd0, 0, 0, 10'h050, 10'h041, 1, 0));
        vecs.push_back(mk(0, 10'h000, 0, 0, 2'd0, 1, 1, 10'h050, 10'h051, 1, 0));
        vecs.push_back(mk(0, 10'h000, 0, 0, 2'd0, 0, 1, 10'h050, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 0, 2'd0, 1, 1, 10'h050, 10'h051, 1, 1));
        vecs.push_back(mk(1, 10'h2AB, 1, 0, 2'd0, 0, 0, 10'h2AB, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h000, 1, 0, 2'd1, 0, 0, 10'h000, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h123, 1, 0, 2'd0, 0, 0, 10'h123, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h000, 1, 0, 2'd2, 1, 0, 10'h3FF, 10'h124, 1, 0));
        vecs.push_back(mk(0, 10'h000, 1, 0, 2'd1, 0, 1, 10'h124, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h3FF, 1, 0, 2'd0, 0, 0, 10'h3FF, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 0, 2'd0, 1, 0, 10'h3FF, 10'h000, 1, 0));

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            step(vecs[k].din, vecs[k].ld, vecs[k].inc, vecs[k].sel, vecs[k].push, vecs[k].pop);
            chk_state($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_top,
                      vecs[k].e_depth, vecs[k].e_err);
        end

        // Fill to capacity with push+inc so entry i holds i+1, then overflow and drain.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step('0, 0, 1, 2'd0, 1, 0);
            chk_state($sformatf("fill%0d", i), 10'(i + 1), 10'(i + 1), i + 1, 0);
        end
        step('0, 0, 1, 2'd0, 1, 0);
        chk_state("ovf", 10'(DEPTH + 1), 10'(DEPTH), DEPTH, 1);
        for (int k = 1; k <= DEPTH; k++) begin
            step('0, 0, 0, 2'd0, 0, 1);
            chk_state($sformatf("drain%0d", k), 10'(DEPTH + 1), 10'(DEPTH - k), DEPTH - k, 1);
        end

        do_reset();
        m_pc  = 0;
        m_err = 0;
        m_stk.delete();
        for (int c = 0; c < 600; c++) begin
            logic [9:0] d  = 10'($urandom_range(0, 1023));
            bit         l  = ($urandom_range(0, 3) == 0);
            bit         i  = $urandom_range(0, 1) == 1;
            logic [1:0] s  = 2'($urandom_range(0, 3));
            bit         pu = (c % 200 < 100) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            bit         po = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            model_step(d, l, i, s, pu, po);
            step(d, l, i, s, pu, po);
            chk_state($sformatf("rnd%0d", c), 10'(m_pc),
                      (m_stk.size() == 0) ? 10'h000 : m_stk[m_stk.size() - 1],
                      m_stk.size(), m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
